// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Brief    : Shares one single-port synchronous memory between the core's
//            instruction-fetch port and its load/store port. Data accesses
//            win arbitration, but a saturating counter guarantees that fetch
//            is served after STARVE_LIMIT consecutive data grants. A stalled
//            access keeps its grant until the memory accepts it, and each
//            read response is routed back to the port that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4      // legal range 1..15
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active-low

    // Instruction-fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,

    // Load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_sel,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,

    // Shared memory port
    output logic            mem_ce,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_sel,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);

    // The starvation counter is 4 bits wide, enough for the full 1..15 range.
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_HOLD_IF = 2'd1,
        ST_HOLD_D  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D_RD = 2'd2,
        RESP_D_WR = 2'd3
    } resp_t;

    state_t     r_state;
    state_t     w_state_nxt;
    owner_t     w_owner;
    owner_t     w_sel;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    resp_t      r_resp_owner;
    resp_t      w_resp_nxt;
    logic       w_accept;

    // State register; reset may arrive mid-access and simply abandons it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner selection and next state: data first unless fetch has waited long enough.
    always_comb begin
        w_state_nxt = r_state;
        w_owner     = OWN_NONE;
        case (r_state)
            ST_ARB: begin
                if (d_req && (!if_req || (r_starve_cnt < C_STARVE_LIMIT))) begin
                    w_owner = OWN_D;
                    if (!mem_ready) begin
                        w_state_nxt = ST_HOLD_D;
                    end
                end else if (if_req) begin
                    w_owner = OWN_IF;
                    if (!mem_ready) begin
                        w_state_nxt = ST_HOLD_IF;
                    end
                end
            end
            ST_HOLD_IF: begin
                // A held requester that drops its request releases the memory
                // without issuing anything.
                if (if_req) begin
                    w_owner = OWN_IF;
                    if (mem_ready) begin
                        w_state_nxt = ST_ARB;
                    end
                end else begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_HOLD_D: begin
                if (d_req) begin
                    w_owner = OWN_D;
                    if (mem_ready) begin
                        w_state_nxt = ST_ARB;
                    end
                end else begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // While reset is low nothing may reach the memory or the grant outputs,
    // even though the requesters keep driving their inputs.
    assign w_sel = rst ? w_owner : OWN_NONE;

    // Memory-side mux of the selected requester; fetch is always a full-word read.
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_sel)
            OWN_IF: begin
                mem_ce   = 1'b1;
                mem_sel  = '1;
                mem_addr = if_addr;
            end
            OWN_D: begin
                mem_ce    = 1'b1;
                mem_we    = d_we;
                mem_sel   = d_sel;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                mem_ce = 1'b0;
            end
        endcase
    end

    assign w_accept = mem_ce & mem_ready;
    assign if_gnt   = w_accept & (w_sel == OWN_IF);
    assign d_gnt    = w_accept & (w_sel == OWN_D);

    // Starvation count: data grants taken while fetch is waiting, saturating.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!if_req || if_gnt) begin
            w_starve_nxt = 4'd0;
        end else if (d_gnt && (r_starve_cnt < C_STARVE_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Remember who was accepted so next cycle's memory data goes to the right port.
    always_comb begin
        w_resp_nxt = RESP_NONE;
        if (if_gnt) begin
            w_resp_nxt = RESP_IF;
        end else if (d_gnt) begin
            w_resp_nxt = d_we ? RESP_D_WR : RESP_D_RD;
        end
    end

    // Response owner register; reset drops any response in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_owner <= RESP_NONE;
        end else begin
            r_resp_owner <= w_resp_nxt;
        end
    end

    // Response routing: write acknowledges carry no data.
    assign if_rvalid = (r_resp_owner == RESP_IF);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rvalid  = (r_resp_owner == RESP_D_RD) || (r_resp_owner == RESP_D_WR);
    assign d_rdata   = (r_resp_owner == RESP_D_RD) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Brief    : Self-checking bench for imem_dmem_arbiter: directed scenarios
//            plus randomized traffic checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_sel;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_ce;
    logic          mem_we;
    logic [3:0]    mem_sel;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    int            total;
    int            bad;
    logic          mem_load;
    logic [31:0]   mem_arr [256];   // memory driven by the DUT's mem_* port
    logic [31:0]   ref_arr [256];   // expected contents, from requester fields

    imem_dmem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    // Synchronous memory: read data one cycle after acceptance, garbage otherwise.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= seed_word(i);
            mem_rdata <= '0;
        end else if (mem_ce && mem_ready) begin
            mem_rdata <= mem_arr[mem_addr[9:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_sel[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end else begin
            mem_rdata <= $urandom;
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b1;
        d_sel = 4'hF; d_addr = 32'h40; d_wdata = 32'h1234_5678; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({if_gnt, d_gnt, mem_ce, mem_we} !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt: got if_gnt/d_gnt/ce/we=%b want 0000", {if_gnt, d_gnt, mem_ce, mem_we});
        end
        total++;
        if (mem_addr !== 32'd0 || mem_sel !== 4'd0 || mem_wdata !== 32'd0) begin
            bad++; $display("FAIL reset_mem: got addr=%h sel=%b wdata=%h want 0", mem_addr, mem_sel, mem_wdata);
        end
        total++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_resp: got rvalid=%b%b rdata=%h/%h want 0", if_rvalid, d_rvalid, if_rdata, d_rdata);
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        next_cycle;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (dut.r_starve_cnt !== 4'd0 || mem_ce !== 1'b0) begin
            bad++; $display("FAIL reset_release: got starve=%0d ce=%b want 0 0", dut.r_starve_cnt, mem_ce);
        end
    endtask

    task automatic test_fetch_only;
        for (int k = 0; k < 4; k++) begin
            next_cycle;
            if_req = (k < 3); if_addr = 32'(4 * k); d_req = 1'b0; mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (if_gnt !== (k < 3)) begin
                bad++; $display("FAIL fetch_gnt k=%0d: got %b want %b", k, if_gnt, (k < 3));
            end
            total++;
            if (d_gnt !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin
                bad++; $display("FAIL fetch_d_quiet k=%0d: got gnt=%b rvalid=%b rdata=%h want 0", k, d_gnt, d_rvalid, d_rdata);
            end
            if (k < 3) begin
                total++;
                if (mem_we !== 1'b0 || mem_sel !== 4'hF || mem_wdata !== 32'd0 || mem_addr !== 32'(4 * k)) begin
                    bad++; $display("FAIL fetch_mem k=%0d: got we=%b sel=%b wdata=%h addr=%h", k, mem_we, mem_sel, mem_wdata, mem_addr);
                end
            end
            if (k > 0) begin
                total++;
                if (if_rvalid !== 1'b1 || if_rdata !== ref_arr[k-1]) begin
                    bad++; $display("FAIL fetch_rdata k=%0d: got v=%b d=%h want 1 %h", k, if_rvalid, if_rdata, ref_arr[k-1]);
                end
            end
        end
    endtask

    task automatic test_contention;
        logic exp_if;
        logic prev_if;
        logic prev_d;
        prev_if = 1'b0; prev_d = 1'b0;
        for (int k = 0; k < 11; k++) begin
            next_cycle;
            if_req = (k < 10); if_addr = 32'h30; d_req = (k < 10); d_we = 1'b0;
            d_sel = 4'hF; d_addr = 32'h80; mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (if_rvalid !== prev_if || d_rvalid !== prev_d) begin
                bad++; $display("FAIL contention_resp k=%0d: got %b%b want %b%b", k, if_rvalid, d_rvalid, prev_if, prev_d);
            end
            exp_if = 1'b0;
            if (k < 10) begin
                exp_if = ((k % 5) == 4);
                total++;
                if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                    bad++; $display("FAIL contention_order k=%0d: got if=%b d=%b want if=%b", k, if_gnt, d_gnt, exp_if);
                end
                total++;
                if (dut.r_starve_cnt !== 4'(k % 5)) begin
                    bad++; $display("FAIL contention_starve k=%0d: got %0d want %0d", k, dut.r_starve_cnt, k % 5);
                end
            end
            prev_if = (k < 10) && exp_if;
            prev_d  = (k < 10) && !exp_if;
        end
    endtask

    task automatic test_stall;
        for (int k = 1; k <= 5; k++) begin
            next_cycle;
            d_req = (k <= 4); d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h100;
            if_req = (k >= 2); if_addr = 32'h8; mem_ready = (k >= 4);
            @(negedge clk);
            if (k <= 3) begin
                total++;
                if (d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_ce !== 1'b1 || mem_addr !== 32'h100) begin
                    bad++; $display("FAIL stall_hold_d k=%0d: got dg=%b ig=%b ce=%b addr=%h", k, d_gnt, if_gnt, mem_ce, mem_addr);
                end
            end
            if (k == 4) begin
                total++;
                if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                    bad++; $display("FAIL stall_grant: got dg=%b ig=%b want 1 0", d_gnt, if_gnt);
                end
            end
            if (k == 5) begin
                total++;
                if (d_rvalid !== 1'b1 || d_rdata !== ref_arr[64]) begin
                    bad++; $display("FAIL stall_rdata: got v=%b d=%h want 1 %h", d_rvalid, d_rdata, ref_arr[64]);
                end
                total++;
                if (if_gnt !== 1'b1) begin
                    bad++; $display("FAIL stall_if_after: got %b want 1", if_gnt);
                end
            end
        end
        // A stalled fetch keeps the memory even when a data request shows up.
        for (int k = 1; k <= 4; k++) begin
            next_cycle;
            if_req = (k <= 3); if_addr = 32'hC;
            d_req = (k >= 2); d_we = 1'b0; d_addr = 32'h44; mem_ready = (k >= 3);
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (if_rvalid !== 1'b1 || if_rdata !== ref_arr[2]) begin
                    bad++; $display("FAIL hold_if_prev_rdata: got v=%b d=%h want 1 %h", if_rvalid, if_rdata, ref_arr[2]);
                end
            end
            if (k <= 2) begin
                total++;
                if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'hC) begin
                    bad++; $display("FAIL hold_if k=%0d: got ig=%b dg=%b addr=%h", k, if_gnt, d_gnt, mem_addr);
                end
            end
            if (k == 3) begin
                total++;
                if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
                    bad++; $display("FAIL hold_if_grant: got ig=%b dg=%b want 1 0", if_gnt, d_gnt);
                end
            end
            if (k == 4) begin
                total++;
                if (d_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== ref_arr[3]) begin
                    bad++; $display("FAIL hold_if_after: got dg=%b v=%b d=%h want 1 1 %h", d_gnt, if_rvalid, if_rdata, ref_arr[3]);
                end
            end
        end
        next_cycle;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_ack;
        next_cycle;
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_sel !== 4'b0011 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL write_mem: got g=%b we=%b sel=%b addr=%h wd=%h", d_gnt, mem_we, mem_sel, mem_addr, mem_wdata);
        end
        ref_arr[8][15:0] = 16'hBEEF;
        next_cycle;
        d_we = 1'b0; d_sel = 4'hF;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'd0 || if_rvalid !== 1'b0) begin
            bad++; $display("FAIL write_ack: got v=%b d=%h iv=%b want 1 0 0", d_rvalid, d_rdata, if_rvalid);
        end
        total++;
        if (d_gnt !== 1'b1) begin
            bad++; $display("FAIL write_b2b_read: got %b want 1", d_gnt);
        end
        next_cycle;
        d_req = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_arr[8]) begin
            bad++; $display("FAIL write_readback: got v=%b d=%h want 1 %h", d_rvalid, d_rdata, ref_arr[8]);
        end
    endtask

    task automatic test_async_reset;
        next_cycle;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++; $display("FAIL areset_pre_gnt: got %b want 1", if_gnt);
        end
        @(posedge clk);
        #2;
        total++;
        if (if_rvalid !== 1'b1) begin
            bad++; $display("FAIL areset_inflight: got %b want 1", if_rvalid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'd0 || if_gnt !== 1'b0 || mem_ce !== 1'b0) begin
            bad++; $display("FAIL areset_drop: got v=%b d=%h g=%b ce=%b want 0", if_rvalid, if_rdata, if_gnt, mem_ce);
        end
        next_cycle;
        rst = 1'b1; d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h60;
        @(negedge clk);
        total++;
        if (dut.r_starve_cnt !== 4'd0 || d_gnt !== 1'b1 || if_gnt !== 1'b0 || if_rvalid !== 1'b0) begin
            bad++; $display("FAIL areset_fresh: got cnt=%0d dg=%b ig=%b iv=%b", dut.r_starve_cnt, d_gnt, if_gnt, if_rvalid);
        end
        next_cycle;
        d_req = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_arr[24] || if_gnt !== 1'b1) begin
            bad++; $display("FAIL areset_after: got dv=%b dd=%h ig=%b want 1 %h 1", d_rvalid, d_rdata, if_gnt, ref_arr[24]);
        end
        // Reset during a stalled data access with fetch already starved twice.
        next_cycle;
        if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h64;
        next_cycle;
        next_cycle;
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (dut.r_starve_cnt !== 4'd2 || d_gnt !== 1'b0 || mem_ce !== 1'b1) begin
            bad++; $display("FAIL areset_stall_pre: got cnt=%0d dg=%b ce=%b want 2 0 1", dut.r_starve_cnt, d_gnt, mem_ce);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (dut.r_starve_cnt !== 4'd0 || mem_ce !== 1'b0 || d_rvalid !== 1'b0) begin
            bad++; $display("FAIL areset_stall: got cnt=%0d ce=%b dv=%b want 0 0 0", dut.r_starve_cnt, mem_ce, d_rvalid);
        end
        next_cycle;
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            bad++; $display("FAIL areset_stall_release: got dg=%b ig=%b want 1 0", d_gnt, if_gnt);
        end
        next_cycle;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_arr[25]) begin
            bad++; $display("FAIL areset_stall_rdata: got v=%b d=%h want 1 %h", d_rvalid, d_rdata, ref_arr[25]);
        end
    endtask

    task automatic test_random;
        int          lock;      // 0 free, 1 fetch holds the memory, 2 data holds it
        int          waits;     // data grants taken while fetch kept waiting
        int          owner;     // 0 none, 1 fetch, 2 data
        int          exp_kind;  // response due now: 0 none, 1 fetch, 2 data read, 3 data write
        logic [31:0] exp_data;
        logic        acc;
        logic        last_if_gnt;
        logic        last_d_gnt;
        next_cycle;
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        lock = 0; waits = 0; exp_kind = 0; exp_data = '0;
        last_if_gnt = 1'b0; last_d_gnt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle;
            if (!if_req || last_if_gnt) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!d_req || last_d_gnt) begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_we    = 1'($urandom_range(0, 1));
                d_sel   = 4'($urandom);
                d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                d_wdata = $urandom;
            end
            mem_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            if (lock == 1)                                   owner = if_req ? 1 : 0;
            else if (lock == 2)                              owner = d_req ? 2 : 0;
            else if (d_req && (!if_req || waits < SL))       owner = 2;
            else if (if_req)                                 owner = 1;
            else                                             owner = 0;
            acc = (owner != 0) && mem_ready;
            total++;
            if (if_gnt !== (acc && owner == 1) || d_gnt !== (acc && owner == 2)) begin
                bad++; $display("FAIL rand_grant c=%0d: got ig=%b dg=%b want owner=%0d acc=%b", c, if_gnt, d_gnt, owner, acc);
            end
            total++;
            if (owner == 1) begin
                if (mem_ce !== 1'b1 || mem_addr !== if_addr || mem_we !== 1'b0 || mem_sel !== 4'hF || mem_wdata !== 32'd0) begin
                    bad++; $display("FAIL rand_mem_if c=%0d: got ce=%b addr=%h want addr=%h", c, mem_ce, mem_addr, if_addr);
                end
            end else if (owner == 2) begin
                if (mem_ce !== 1'b1 || mem_addr !== d_addr || mem_we !== d_we || mem_sel !== d_sel || mem_wdata !== d_wdata) begin
                    bad++; $display("FAIL rand_mem_d c=%0d: got ce=%b addr=%h we=%b want addr=%h we=%b", c, mem_ce, mem_addr, mem_we, d_addr, d_we);
                end
            end else begin
                if (mem_ce !== 1'b0 || mem_addr !== 32'd0 || mem_we !== 1'b0 || mem_sel !== 4'd0 || mem_wdata !== 32'd0) begin
                    bad++; $display("FAIL rand_mem_idle c=%0d: got ce=%b addr=%h want 0", c, mem_ce, mem_addr);
                end
            end
            total++;
            if (if_rvalid !== (exp_kind == 1) || if_rdata !== ((exp_kind == 1) ? exp_data : 32'd0)) begin
                bad++; $display("FAIL rand_if_resp c=%0d: got v=%b d=%h want kind=%0d d=%h", c, if_rvalid, if_rdata, exp_kind, exp_data);
            end
            total++;
            if (d_rvalid !== (exp_kind >= 2) || d_rdata !== ((exp_kind == 2) ? exp_data : 32'd0)) begin
                bad++; $display("FAIL rand_d_resp c=%0d: got v=%b d=%h want kind=%0d d=%h", c, d_rvalid, d_rdata, exp_kind, exp_data);
            end
            exp_kind = 0; exp_data = '0;
            if (acc && owner == 1) begin
                exp_kind = 1; exp_data = ref_arr[if_addr[9:2]];
            end else if (acc && owner == 2) begin
                if (d_we) begin
                    exp_kind = 3;
                    for (int b = 0; b < 4; b++)
                        if (d_sel[b]) ref_arr[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    exp_kind = 2; exp_data = ref_arr[d_addr[9:2]];
                end
            end
            if (!if_req)                                  waits = 0;
            else if (acc && owner == 1)                   waits = 0;
            else if (acc && owner == 2 && waits < SL)     waits = waits + 1;
            lock = (owner != 0 && !mem_ready) ? owner : 0;
            last_if_gnt = if_gnt;
            last_d_gnt  = d_gnt;
        end
        next_cycle;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rvalid !== (exp_kind == 1) || d_rvalid !== (exp_kind >= 2)) begin
            bad++; $display("FAIL rand_drain: got iv=%b dv=%b want kind=%0d", if_rvalid, d_rvalid, exp_kind);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; mem_load = 1'b1; mem_ready = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_sel = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) ref_arr[i] = seed_word(i);
        @(posedge clk);
        #1;
        mem_load = 1'b0;
        test_reset;
        test_fetch_only;
        test_contention;
        test_stall;
        test_write_ack;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
